cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Sequential arbiter for the single common data bus. Each of the five functional-unit result ports (LS, MULT0, MULT1, ALU, BR) writes its completed result into a small per-source FIFO. A round-robin arbiter grants exactly one FIFO head per cycle and drives the registered CDB broadcast. Per-source ready signals back-pressure the FUs, so results are never dropped when several units finish in the same cycle. The block sits between the FU completion outputs and the RS/ROB/map-table CDB consumers.

## Interface
Parameters:
- NUM_SRC, 5, number of result sources. Index map: 0=LS, 1=MULT0, 2=MULT1, 3=ALU, 4=BR.
- DEPTH, 2, entries per source FIFO; power of two, ≥2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  synchronous flush on mispredict.
- src_valid  in  [NUM_SRC]  result offered by source i.
- src_tag  in  [NUM_SRC][`TAG_SIZE]  destination tag of source i.
- src_value  in  [NUM_SRC][`XLEN]  result value of source i.
- src_ready  out  [NUM_SRC]  source i's FIFO can accept a result this cycle.
- cdb_out  out  CDB_OUTPUT  registered broadcast: valid, tag, value, fu_opcode, clear.
- cdb_grant  out  [NUM_SRC]  one-hot index of the source granted this cycle (combinational, for debug/perf).

## Operation
- Push: source i is accepted when src_valid[i] && src_ready[i]. It is written at the FIFO tail.
- src_ready[i] = (count[i] != DEPTH). It depends only on registered count, never on the current grant, so a full FIFO refuses a push even if it is popped in the same cycle.
- Arbitration: a source is eligible when count[i] != 0. Search starts at rr_ptr and wraps upward mod NUM_SRC. The first eligible source is granted and its head is popped.
- rr_ptr update: after a grant to index g, rr_ptr ← (g+1) mod NUM_SRC. With no grant, rr_ptr holds.
- Broadcast register, with a grant: cdb_out.valid=1, clear=1, tag/value from the granted head, and fu_opcode from the index map (LS_FU, MULT0_FU, MULT1_FU, ALU_FU, BR_FU).
- Broadcast register, without a grant: valid=0 and clear=0; tag, value and fu_opcode hold their last values.
- Push and pop on the same FIFO in the same cycle: count is unchanged and both pointers advance. The pointers are log2(DEPTH) bits and wrap naturally.
- Push into an empty FIFO is not eligible until the next cycle; there is no bypass.
- Squash: at the next edge all counts and pointers are 0, rr_ptr=0, and cdb_out.valid=0. Pushes offered in the squash cycle are discarded. The grant in the squash cycle is discarded.
- Reset (asynchronous, while reset is low):
  - counts, pointers and rr_ptr are 0;
  - all cdb_out fields are 0;
  - src_ready is forced to all-zero.

## Timing
- Minimum latency is 2 cycles, from a push accepted at the edge ending cycle N to cdb_out.valid visible in cycle N+2.
- Throughput is one broadcast per cycle when any FIFO is non-empty.
- Worst-case wait for a head is NUM_SRC-1 grants (round-robin fairness).
- src_ready returns to 1 in the cycle after a pop from a full FIFO.
- Reset deassertion: src_ready rises combinationally once reset is high. The first legal push is at the first edge after release.

## Structure
- Shared package (sys_defs):
  - NUM_CDB_SRC = 5;
  - the FU opcode enum (LS_FU, MULT0_FU, MULT1_FU, ALU_FU, BR_FU);
  - the CDB_OUTPUT struct;
  - the source-index-to-opcode constant array.
- Sub-module cdb_src_fifo, instantiated NUM_SRC times:
  - DEPTH-entry FIFO of {tag, value};
  - ports: push, pop, full, empty, head_tag, head_value, flush;
  - same clock and reset.
- The arbiter, rr_ptr and broadcast register stay in cdb_arbiter.

## Test plan
- Single ALU result tag=5, value=42, pushed in cycle 1 → cdb_out valid in cycle 3 with tag 5, value 42, fu_opcode ALU_FU; valid=0 in cycle 4.
- All five sources push in the same cycle, from reset (rr_ptr=0) → broadcasts in consecutive cycles in order LS, MULT0, MULT1, ALU, BR; all src_ready stay 1.
- MULT0 offers 3 results back-to-back while LS is continuously busy:
  - MULT0's src_ready drops after 2 accepted pushes;
  - LS and MULT0 then alternate grants;
  - no result is lost or duplicated.
- Squash asserted with 2 entries in each FIFO → next cycle cdb_out.valid=0; no stale tag is ever broadcast; rr_ptr is 0.
- Reset pulled low mid-burst, asynchronously between edges → cdb_out and src_ready go to 0 immediately. After release, a new push of tag 7 broadcasts 2 cycles later with nothing stale ahead of it.
- Pointer wrap: 10 push/pop pairs on BR only → values are broadcast in FIFO order with correct tags throughout.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs: shared CDB widths, FU opcode enum, CDB_OUTPUT struct and source-index-to-opcode map
package sys_defs;
  localparam int NUM_CDB_SRC = 5;
  localparam int TAG_SIZE = 6;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {LS_FU, MULT0_FU, MULT1_FU, ALU_FU, BR_FU} fu_opcode_t;
  typedef struct packed {
    logic valid;
    logic [TAG_SIZE-1:0] tag;
    logic [XLEN-1:0] value;
    fu_opcode_t fu_opcode;
    logic clear;
  } CDB_OUTPUT;
  localparam fu_opcode_t SRC_OPCODE [NUM_CDB_SRC] = '{LS_FU, MULT0_FU, MULT1_FU, ALU_FU, BR_FU};
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: DEPTH-entry {tag,value} FIFO; ports clock/reset(async low), flush, push/push_tag/push_value, pop, full/empty, head_tag/head_value
import sys_defs::*;
module cdb_src_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [TAG_SIZE-1:0] push_tag,
  input  logic [XLEN-1:0]     push_value,
  output logic                full,
  output logic                empty,
  output logic [TAG_SIZE-1:0] head_tag,
  output logic [XLEN-1:0]     head_value
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [TAG_SIZE-1:0] tag_mem [DEPTH];
  logic [XLEN-1:0] value_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head_tag = tag_mem[rd_ptr];
  assign head_value = value_mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (push) begin
      tag_mem[wr_ptr] <= push_tag;
      value_mem[wr_ptr] <= push_value;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source FIFOs + round-robin CDB arbiter; ports clock/reset(async low), squash, src_valid/tag/value in, src_ready, registered cdb_out, debug cdb_grant out
import sys_defs::*;
module cdb_arbiter #(
  parameter int NUM_SRC = NUM_CDB_SRC,
  parameter int DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC-1:0][TAG_SIZE-1:0]  src_tag,
  input  logic [NUM_SRC-1:0][XLEN-1:0]      src_value,
  output logic [NUM_SRC-1:0]                src_ready,
  output CDB_OUTPUT                         cdb_out,
  output logic [NUM_SRC-1:0]                cdb_grant
);
  localparam int PW = $clog2(NUM_SRC);
  logic [NUM_SRC-1:0] full, empty;
  logic [TAG_SIZE-1:0] head_tag [NUM_SRC];
  logic [XLEN-1:0] head_value [NUM_SRC];
  logic [PW-1:0] rr_ptr, gidx;
  logic found;
  assign src_ready = reset ? ~full : '0;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (squash),
      .push       (src_valid[i] & src_ready[i]),
      .pop        (cdb_grant[i]),
      .push_tag   (src_tag[i]),
      .push_value (src_value[i]),
      .full       (full[i]),
      .empty      (empty[i]),
      .head_tag   (head_tag[i]),
      .head_value (head_value[i])
    );
  end
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && !empty[PW'((int'(rr_ptr) + k) % NUM_SRC)]) begin
        found = 1'b1;
        gidx = PW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end
  assign cdb_grant = found ? (NUM_SRC'(1) << gidx) : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_out <= '0;
      rr_ptr <= '0;
    end else if (squash) begin
      cdb_out.valid <= 1'b0;
      cdb_out.clear <= 1'b0;
      rr_ptr <= '0;
    end else if (found) begin
      cdb_out <= '{valid: 1'b1, tag: head_tag[gidx], value: head_value[gidx],
                   fu_opcode: SRC_OPCODE[gidx], clear: 1'b1};
      rr_ptr <= (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
    end else begin
      cdb_out.valid <= 1'b0;
      cdb_out.clear <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized + directed scoreboard bench for cdb_arbiter against a queue-based reference model
import sys_defs::*;
module tb_cdb_arbiter;
  localparam int N = 5;
  localparam int DEPTH = 2;
  typedef struct {logic [5:0] tag; logic [31:0] value;} ent_t;
  typedef struct {logic [5:0] tag; logic [31:0] value; fu_opcode_t op;} bc_t;
  logic clock, reset, squash;
  logic [N-1:0] src_valid, src_ready, cdb_grant;
  logic [N-1:0][5:0] src_tag;
  logic [N-1:0][31:0] src_value;
  CDB_OUTPUT cdb_out;
  int checks = 0;
  int errors = 0;
  ent_t mq [N][$];
  bc_t exp_q [$];
  fu_opcode_t op_map [N] = '{LS_FU, MULT0_FU, MULT1_FU, ALU_FU, BR_FU};
  int rr, g;
  bit exp_valid;
  bit [N-1:0] rdy, exp_rdy;
  bc_t b;
  logic [5:0] l_tag;
  logic [31:0] l_val;
  fu_opcode_t l_op;
  cdb_arbiter #(.NUM_SRC(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .squash(squash), .src_valid(src_valid),
    .src_tag(src_tag), .src_value(src_value), .src_ready(src_ready),
    .cdb_out(cdb_out), .cdb_grant(cdb_grant)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  // Reference model: queues per source, grant the first non-empty queue at or after rr.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      foreach (mq[i]) mq[i].delete();
      exp_q.delete();
      rr = 0;
      exp_valid = 0;
    end else if (squash) begin
      foreach (mq[i]) mq[i].delete();
      rr = 0;
      exp_valid = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(rr + k) % N].size() != 0) g = (rr + k) % N;
      for (int i = 0; i < N; i++) rdy[i] = mq[i].size() != DEPTH;
      exp_valid = g >= 0;
      if (g >= 0) begin
        ent_t e;
        e = mq[g].pop_front();
        exp_q.push_back('{e.tag, e.value, op_map[g]});
        rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (src_valid[i] && rdy[i]) mq[i].push_back('{src_tag[i], src_value[i]});
    end
  end
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (cdb_out !== '0 || src_ready !== '0) begin
        errors++;
        $display("FAIL reset_outputs: cdb_out=%h src_ready=%b, required 0 and 0", cdb_out, src_ready);
      end
      l_tag = 0;
      l_val = 0;
      l_op = LS_FU;
    end else begin
      for (int i = 0; i < N; i++) exp_rdy[i] = mq[i].size() != DEPTH;
      checks++;
      if (src_ready !== exp_rdy) begin
        errors++;
        $display("FAIL src_ready @%0t: got %b, required %b", $time, src_ready, exp_rdy);
      end
      if (exp_valid && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        l_tag = b.tag;
        l_val = b.value;
        l_op = b.op;
      end
      checks++;
      if ({cdb_out.valid, cdb_out.clear, cdb_out.tag, cdb_out.value, cdb_out.fu_opcode} !==
          {exp_valid, exp_valid, l_tag, l_val, l_op}) begin
        errors++;
        $display("FAIL cdb_out @%0t: got v=%b c=%b tag=%0d val=%h op=%0d, required v=%b c=%b tag=%0d val=%h op=%0d",
                 $time, cdb_out.valid, cdb_out.clear, cdb_out.tag, cdb_out.value, cdb_out.fu_opcode,
                 exp_valid, exp_valid, l_tag, l_val, l_op);
      end
    end
  end
  task automatic drive(input logic [N-1:0] v, input logic sq);
    @(negedge clock);
    #1;
    src_valid = v;
    squash = sq;
    for (int i = 0; i < N; i++) begin
      src_tag[i] = 6'($urandom);
      src_value[i] = $urandom;
    end
  endtask
  initial begin
    reset = 0;
    squash = 0;
    src_valid = '0;
    src_tag = '0;
    src_value = '0;
    repeat (2) @(negedge clock);
    #1;
    reset = 1;
    #1;
    checks++;
    if (src_ready !== 5'h1f || cdb_out !== '0) begin
      errors++;
      $display("FAIL post_reset: src_ready=%b cdb_out=%h, required 11111 and 0", src_ready, cdb_out);
    end
    drive(5'b01000, 0);
    src_tag[3] = 6'd5;
    src_value[3] = 32'd42;
    repeat (4) drive('0, 0);
    drive(5'h1f, 0);
    repeat (7) drive('0, 0);
    repeat (6) drive(5'b00011, 0);
    repeat (6) drive('0, 0);
    repeat (3) drive(5'h1f, 0);
    drive(5'h1f, 1);
    repeat (3) drive('0, 0);
    repeat (2) drive(5'h1f, 0);
    @(posedge clock);
    #2;
    reset = 0;
    #1;
    checks++;
    if (cdb_out !== '0 || src_ready !== '0) begin
      errors++;
      $display("FAIL async_reset: cdb_out=%h src_ready=%b, required 0 and 0", cdb_out, src_ready);
    end
    src_valid = '0;
    @(posedge clock);
    #3;
    reset = 1;
    #1;
    checks++;
    if (src_ready !== 5'h1f) begin
      errors++;
      $display("FAIL ready_after_release: got %b, required 11111", src_ready);
    end
    drive(5'b01000, 0);
    src_tag[3] = 6'd7;
    repeat (4) drive('0, 0);
    repeat (10) drive(5'b10000, 0);
    repeat (4) drive('0, 0);
    for (int c = 0; c < 400; c++)
      drive(N'($urandom), ($urandom_range(31) == 0));
    repeat (12) drive('0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected broadcasts never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
